// File: rtl/id_stage_pkg.sv
// Shared core constants for the decode stage: widths, RV32I opcodes,
// instruction-format encoding and the ID/EX pipeline register layout.
package id_stage_pkg;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;

  // RV32I major opcodes (instr[6:0]); execute decodes these same values.
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Instruction encoding format; FMT_NONE covers opcodes this core does not know.
  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_NONE
  } fmt_e;

  // ID/EX payload, everything execute needs besides the valid bit.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1Val;
    logic [XLEN-1:0]   rs2Val;
    logic [XLEN-1:0]   imm;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              funct7b5;
  } idex_t;

  // Only R, S and B formats actually read rs2; other formats reuse those bits.
  function automatic logic fmtUsesRs2(input fmt_e fmt);
    return (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
  endfunction

  // Stores and branches carry immediate bits in the rd field and never write back.
  function automatic logic fmtWritesRd(input fmt_e fmt);
    return !((fmt == FMT_S) || (fmt == FMT_B));
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bus bundle around the decode stage: fetch handshake, register-bank read
// port, writeback bypass, redirect and the ID/EX outputs toward execute.
interface id_stage_if;
  import id_stage_pkg::*;

  logic              if_valid;
  logic [XLEN-1:0]   if_instr;
  logic [XLEN-1:0]   if_pc;
  logic              id_ready;

  logic [ADDR_W-1:0] rf_r_reg1;
  logic [ADDR_W-1:0] rf_r_reg2;
  logic [XLEN-1:0]   rf_rdata1;
  logic [XLEN-1:0]   rf_rdata2;

  logic              wb_en;
  logic [ADDR_W-1:0] wb_reg;
  logic [XLEN-1:0]   wb_data;

  logic              flush;
  logic              ex_ready;

  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_rs1_val;
  logic [XLEN-1:0]   ex_rs2_val;
  logic [XLEN-1:0]   ex_imm;
  logic [ADDR_W-1:0] ex_rs1;
  logic [ADDR_W-1:0] ex_rs2;
  logic [ADDR_W-1:0] ex_rd;
  logic [6:0]        ex_opcode;
  logic [2:0]        ex_funct3;
  logic              ex_funct7b5;

  // Decode stage side.
  modport slave (
    input  if_valid, if_instr, if_pc,
    output id_ready,
    output rf_r_reg1, rf_r_reg2,
    input  rf_rdata1, rf_rdata2,
    input  wb_en, wb_reg, wb_data,
    input  flush, ex_ready,
    output ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
    output ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7b5
  );

  // Surrounding pipeline side (fetch, register bank, writeback, execute).
  modport master (
    output if_valid, if_instr, if_pc,
    input  id_ready,
    input  rf_r_reg1, rf_r_reg2,
    output rf_rdata1, rf_rdata2,
    output wb_en, wb_reg, wb_data,
    output flush, ex_ready,
    input  ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
    input  ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7b5
  );

endinterface

// File: rtl/id_stage_imm_gen.sv
// Combinational format decode and immediate generation for RV32I.
// Every immediate sign-extends from instruction bit 31.
module id_stage_imm_gen
  import id_stage_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o,
  output logic            usesRs2_o
);

  // Map the major opcode onto its encoding format.
  always_comb begin
    fmt_o = FMT_NONE;
    case (instr_i[6:0])
      OPC_LOAD, OPC_JALR, OPC_OP_IMM: fmt_o = FMT_I;
      OPC_STORE:                      fmt_o = FMT_S;
      OPC_BRANCH:                     fmt_o = FMT_B;
      OPC_LUI, OPC_AUIPC:             fmt_o = FMT_U;
      OPC_JAL:                        fmt_o = FMT_J;
      OPC_OP:                         fmt_o = FMT_R;
      default:                        fmt_o = FMT_NONE;
    endcase
  end

  // Reassemble the scattered immediate bits for the decoded format.
  always_comb begin
    imm_o = '0;
    case (fmt_o)
      FMT_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
      FMT_U: imm_o = {instr_i[31:12], 12'b0};
      FMT_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

  assign usesRs2_o = fmtUsesRs2(fmt_o);

endmodule

// File: rtl/id_stage.sv
// Decode stage of the RV32I pipeline: drives register-bank read addresses,
// bypasses a same-cycle writeback, detects load-use hazards and holds the
// ID/EX register consumed by execute.
module id_stage
  import id_stage_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  id_stage_if.slave bus
);

  logic [XLEN-1:0]   immVal;
  fmt_e              fmt;
  logic              usesRs2;
  logic [ADDR_W-1:0] rs1Idx;
  logic [ADDR_W-1:0] rs2Idx;
  logic [XLEN-1:0]   rs1Val;
  logic [XLEN-1:0]   rs2Val;
  logic              hazard;
  logic              advance;

  logic              exValid_q;
  logic              exValid_d;
  idex_t             payload_q;
  idex_t             payload_d;

  assign rs1Idx        = bus.if_instr[19:15];
  assign rs2Idx        = bus.if_instr[24:20];
  assign bus.rf_r_reg1 = rs1Idx;
  assign bus.rf_r_reg2 = rs2Idx;

  id_stage_imm_gen u_immGen (
    .instr_i   (bus.if_instr),
    .imm_o     (immVal),
    .fmt_o     (fmt),
    .usesRs2_o (usesRs2)
  );

  // Operand select: x0 reads as zero, then same-cycle writeback wins over the bank.
  always_comb begin
    rs1Val = bus.rf_rdata1;
    rs2Val = bus.rf_rdata2;
    if (rs1Idx == '0) begin
      rs1Val = '0;
    end else if (bus.wb_en && (bus.wb_reg == rs1Idx)) begin
      rs1Val = bus.wb_data;
    end
    if (rs2Idx == '0) begin
      rs2Val = '0;
    end else if (bus.wb_en && (bus.wb_reg == rs2Idx)) begin
      rs2Val = bus.wb_data;
    end
  end

  // Load-use: a load sitting in ID/EX whose destination feeds the instruction in decode.
  always_comb begin
    hazard = 1'b0;
    if (exValid_q && (payload_q.opcode == OPC_LOAD) && (payload_q.rd != '0)) begin
      if (payload_q.rd == rs1Idx) begin
        hazard = 1'b1;
      end else if (usesRs2 && (payload_q.rd == rs2Idx)) begin
        hazard = 1'b1;
      end
    end
  end

  assign advance      = !exValid_q || bus.ex_ready;
  assign bus.id_ready = advance && !hazard && !bus.flush;

  // Next ID/EX content: flush kills, hazard bubbles, advance captures, otherwise stall.
  always_comb begin
    exValid_d = exValid_q;
    payload_d = payload_q;
    if (bus.flush) begin
      exValid_d = 1'b0;
    end else if (advance && hazard) begin
      exValid_d = 1'b0;
    end else if (advance) begin
      exValid_d          = bus.if_valid;
      payload_d.pc       = bus.if_pc;
      payload_d.rs1Val   = rs1Val;
      payload_d.rs2Val   = rs2Val;
      payload_d.imm      = immVal;
      payload_d.rs1      = rs1Idx;
      payload_d.rs2      = rs2Idx;
      payload_d.rd       = fmtWritesRd(fmt) ? bus.if_instr[11:7] : '0;
      payload_d.opcode   = bus.if_instr[6:0];
      payload_d.funct3   = bus.if_instr[14:12];
      payload_d.funct7b5 = bus.if_instr[30];
    end
  end

  // ID/EX register; reset clears valid and payload alike.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exValid_q <= 1'b0;
      payload_q <= '0;
    end else begin
      exValid_q <= exValid_d;
      payload_q <= payload_d;
    end
  end

  assign bus.ex_valid    = exValid_q;
  assign bus.ex_pc       = payload_q.pc;
  assign bus.ex_rs1_val  = payload_q.rs1Val;
  assign bus.ex_rs2_val  = payload_q.rs2Val;
  assign bus.ex_imm      = payload_q.imm;
  assign bus.ex_rs1      = payload_q.rs1;
  assign bus.ex_rs2      = payload_q.rs2;
  assign bus.ex_rd       = payload_q.rd;
  assign bus.ex_opcode   = payload_q.opcode;
  assign bus.ex_funct3   = payload_q.funct3;
  assign bus.ex_funct7b5 = payload_q.funct7b5;

endmodule
